// File: rtl/pci_pkg.sv
// Shared definitions for the PCI bus-master scheduler and the arbiter family.
// Provides the sequencer state encoding, the latency-timer width and the default grant timeout.
package pci_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_GRANT = 3'd2,
        ST_XFER  = 3'd3,
        ST_TURN  = 3'd4
    } state_t;

    localparam int PCI_LT_W       = 8;
    localparam int PCI_GNT_TO_DEF = 16;

endpackage

// File: rtl/pci_rr_pick.sv
// Combinational round-robin picker: first requester strictly after 'last', wrapping to 0.
// Zero latency, no flow control; vld is low when no request is pending.
module pci_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] idx,
    output logic         vld
);

    always_comb begin
        idx = '0;
        vld = 1'b0;
        // i runs to N so 'last' itself is the lowest-priority candidate
        for (int i = 1; i <= N; i++) begin
            if (!vld && req[W'((int'(last) + i) % N)]) begin
                vld = 1'b1;
                idx = W'((int'(last) + i) % N);
            end
        end
    end

endmodule

// File: rtl/pci_master_sched.sv
// Shares one PCI REQ#/GNT# pair among NCLI master engines: round-robin pick, registered grant (REQ# one clock after cli_req).
// Engines wait on cli_gnt; the latency timer flags lt_expire. Optional PCI_SCHED_KEEPREQ_EN holds REQ# for back-to-back transfers.
module pci_master_sched
    import pci_pkg::*;
#(
    parameter int NCLI   = 4,
    parameter int GNT_TO = PCI_GNT_TO_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCLI-1:0]     cli_req,
    output logic [NCLI-1:0]     cli_gnt,
    output logic                req_l,
    input  logic                gnt_l,
    input  logic                frame_l,
    input  logic                irdy_l,
    input  logic [PCI_LT_W-1:0] lat_timer,
    output logic                lt_expire,
    output logic                busy
);

    localparam int PW   = $clog2(NCLI);
    localparam int TO_W = (GNT_TO > 1) ? $clog2(GNT_TO) : 1;

    state_t              state_q, state_d;
    logic [PW-1:0]       win_q, win_d, last_q, last_d, pick_idx;
    logic                pick_vld;
    logic                req_l_q, req_l_d;
    logic                lt_exp_q, lt_exp_d;
    logic [NCLI-1:0]     gnt_q, gnt_d, win_oh;
    logic [PCI_LT_W-1:0] lt_q, lt_d, lt_nxt;
    logic [TO_W-1:0]     to_q, to_d;
    logic                bus_idle, keep;

    assign bus_idle = frame_l & irdy_l;
    assign win_oh   = NCLI'(1) << win_q;
    assign lt_nxt   = (lt_q == '0) ? '0 : lt_q - PCI_LT_W'(1);

`ifdef PCI_SCHED_KEEPREQ_EN
    // Another engine waiting: keep REQ# low so the central arbiter can leave GNT# with us
    assign keep = |(cli_req & ~win_oh);
`else
    assign keep = 1'b0;
`endif

    pci_rr_pick #(.N(NCLI), .W(PW)) u_pick (
        .req  (cli_req),
        .last (last_q),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        last_d   = last_q;
        req_l_d  = req_l_q;
        gnt_d    = gnt_q;
        lt_d     = lt_q;
        lt_exp_d = lt_exp_q;
        to_d     = to_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    win_d   = pick_idx;
                    req_l_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!cli_req[win_q]) begin
                    req_l_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (!gnt_l && bus_idle) begin
                    gnt_d   = win_oh;
                    to_d    = TO_W'(GNT_TO - 1);
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!frame_l) begin
                    lt_d    = lat_timer;
                    state_d = ST_XFER;
                end else if (gnt_l) begin
                    gnt_d   = '0;
                    state_d = ST_REQ;
                end else if (to_q == '0) begin
                    // last_q untouched, so the same engine is retried first
                    gnt_d   = '0;
                    req_l_d = 1'b1;
                    state_d = ST_TURN;
                end else begin
                    to_d = to_q - TO_W'(1);
                end
            end
            ST_XFER: begin
                req_l_d = ~keep;
                lt_d    = lt_nxt;
                if (bus_idle) begin
                    gnt_d    = '0;
                    last_d   = win_q;
                    lt_exp_d = 1'b0;
                    state_d  = ST_TURN;
                end else begin
                    lt_exp_d = lt_exp_q | ((lt_nxt == '0) & gnt_l);
                end
            end
            ST_TURN: begin
                lt_exp_d = 1'b0;
                req_l_d  = 1'b1;
                state_d  = ST_IDLE;
                if (keep && pick_vld) begin
                    win_d   = pick_idx;
                    req_l_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            last_q   <= PW'(NCLI - 1);
            req_l_q  <= 1'b1;
            gnt_q    <= '0;
            lt_q     <= '0;
            lt_exp_q <= 1'b0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            last_q   <= last_d;
            req_l_q  <= req_l_d;
            gnt_q    <= gnt_d;
            lt_q     <= lt_d;
            lt_exp_q <= lt_exp_d;
            to_q     <= to_d;
        end
    end

    assign cli_gnt   = gnt_q;
    assign req_l     = req_l_q;
    assign lt_expire = lt_exp_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pci_master_sched.sv
// Directed bench for pci_master_sched: reset, fairness, single client, latency timer,
// grant timeout, GNT# withdrawal and asynchronous reset during a transfer.
module tb_pci_master_sched;

    logic       clk;
    logic       reset;
    logic [3:0] cli_req;
    logic [3:0] cli_gnt;
    logic       req_l;
    logic       gnt_l;
    logic       frame_l;
    logic       irdy_l;
    logic [7:0] lat_timer;
    logic       lt_expire;
    logic       busy;

    int total = 0;
    int bad   = 0;

    pci_master_sched #(.NCLI(4), .GNT_TO(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .cli_req   (cli_req),
        .cli_gnt   (cli_gnt),
        .req_l     (req_l),
        .gnt_l     (gnt_l),
        .frame_l   (frame_l),
        .irdy_l    (irdy_l),
        .lat_timer (lat_timer),
        .lt_expire (lt_expire),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt();
        int n;
        n = 0;
        while (cli_gnt == 4'b0000 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cli_req = 4'b0000; gnt_l = 1'b1; frame_l = 1'b1; irdy_l = 1'b1; lat_timer = 8'd0;
        tick(); tick();
        total++; if (req_l !== 1'b1) begin bad++; $display("FAIL reset_req_l: got %b want 1", req_l); end
        total++; if (cli_gnt !== 4'b0000) begin bad++; $display("FAIL reset_cli_gnt: got %b want 0000", cli_gnt); end
        total++; if (lt_expire !== 1'b0) begin bad++; $display("FAIL reset_lt_expire: got %b want 0", lt_expire); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        cli_req = 4'b1111; gnt_l = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt();
            total++;
            if (cli_gnt !== exp_seq[k]) begin
                bad++; $display("FAIL fair_gnt%0d: got %b want %b", k, cli_gnt, exp_seq[k]);
            end
            frame_l = 1'b0; irdy_l = 1'b0; tick();
            frame_l = 1'b1; irdy_l = 1'b1;
            if (k == 4) cli_req = 4'b0000;
            tick();
        end
        gnt_l = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic test_single();
        cli_req = 4'b0010;
        total++; if (req_l !== 1'b1) begin bad++; $display("FAIL single_req_l_early: got %b want 1", req_l); end
        tick();
        total++; if (req_l !== 1'b0) begin bad++; $display("FAIL single_req_l_low: got %b want 0", req_l); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
        tick(); tick();
        total++; if (cli_gnt !== 4'b0000) begin bad++; $display("FAIL single_no_gnt: got %b want 0000", cli_gnt); end
        gnt_l = 1'b0;
        tick();
        total++; if (cli_gnt !== 4'b0010) begin bad++; $display("FAIL single_gnt: got %b want 0010", cli_gnt); end
        frame_l = 1'b0; irdy_l = 1'b0;
        tick(); tick();
        total++; if (cli_gnt !== 4'b0010) begin bad++; $display("FAIL single_xfer_gnt: got %b want 0010", cli_gnt); end
        total++; if (req_l !== 1'b1) begin bad++; $display("FAIL single_xfer_req_l: got %b want 1", req_l); end
        tick();
        frame_l = 1'b1; irdy_l = 1'b1; cli_req = 4'b0000; gnt_l = 1'b1;
        tick();
        total++; if (cli_gnt !== 4'b0000) begin bad++; $display("FAIL single_end_gnt: got %b want 0000", cli_gnt); end
        total++; if (req_l !== 1'b1) begin bad++; $display("FAIL single_end_req_l: got %b want 1", req_l); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_turn_busy: got %b want 1", busy); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_lat_timer();
        int first;
        int hi;
        lat_timer = 8'd8; cli_req = 4'b0001; gnt_l = 1'b0;
        wait_gnt();
        frame_l = 1'b0; irdy_l = 1'b0;
        tick();
        first = 0; hi = 0;
        for (int c = 1; c <= 20; c++) begin
            if (lt_expire === 1'b1) begin
                hi++;
                if (first == 0) first = c;
            end
            if (c == 3) gnt_l = 1'b1;
            if (c == 20) begin frame_l = 1'b1; irdy_l = 1'b1; cli_req = 4'b0000; end
            tick();
        end
        total++; if (first != 9) begin bad++; $display("FAIL lt8_first: got %0d want 9", first); end
        total++; if (hi != 12) begin bad++; $display("FAIL lt8_cycles: got %0d want 12", hi); end
        total++; if (lt_expire !== 1'b0) begin bad++; $display("FAIL lt8_clear: got %b want 0", lt_expire); end
        tick();
        lat_timer = 8'd0; cli_req = 4'b0001; gnt_l = 1'b0;
        wait_gnt();
        frame_l = 1'b0; irdy_l = 1'b0;
        tick();
        total++; if (lt_expire !== 1'b0) begin bad++; $display("FAIL lt0_c1: got %b want 0", lt_expire); end
        gnt_l = 1'b1;
        tick();
        total++; if (lt_expire !== 1'b1) begin bad++; $display("FAIL lt0_c2: got %b want 1", lt_expire); end
        frame_l = 1'b1; irdy_l = 1'b1; cli_req = 4'b0000;
        tick();
        total++; if (lt_expire !== 1'b0) begin bad++; $display("FAIL lt0_end: got %b want 0", lt_expire); end
        tick();
        cli_req = 4'b0001; gnt_l = 1'b0;
        wait_gnt();
        frame_l = 1'b0; irdy_l = 1'b0;
        tick();
        gnt_l = 1'b1; frame_l = 1'b1; irdy_l = 1'b1; cli_req = 4'b0000;
        tick();
        total++; if (lt_expire !== 1'b0) begin bad++; $display("FAIL lt_end_wins: got %b want 0", lt_expire); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL lt_end_turn: got %b want 1", busy); end
        tick();
        total++; if (lt_expire !== 1'b0) begin bad++; $display("FAIL lt_end_idle: got %b want 0", lt_expire); end
    endtask

    task automatic test_timeout();
        int n;
        cli_req = 4'b0100; gnt_l = 1'b0;
        wait_gnt();
        total++; if (cli_gnt !== 4'b0100) begin bad++; $display("FAIL to_gnt: got %b want 0100", cli_gnt); end
        cli_req = 4'b1100;
        n = 0;
        while (cli_gnt != 4'b0000 && n < 40) begin
            n++;
            tick();
        end
        total++; if (n != 16) begin bad++; $display("FAIL to_cycles: got %0d want 16", n); end
        total++; if (req_l !== 1'b1) begin bad++; $display("FAIL to_req_l: got %b want 1", req_l); end
        wait_gnt();
        total++; if (cli_gnt !== 4'b0100) begin bad++; $display("FAIL to_retry: got %b want 0100", cli_gnt); end
        frame_l = 1'b0; irdy_l = 1'b0; tick();
        frame_l = 1'b1; irdy_l = 1'b1; cli_req = 4'b0000; tick();
        gnt_l = 1'b1; tick(); tick();
    endtask

    task automatic test_gnt_withdraw();
        cli_req = 4'b1000; gnt_l = 1'b0;
        wait_gnt();
        total++; if (cli_gnt !== 4'b1000) begin bad++; $display("FAIL wd_gnt: got %b want 1000", cli_gnt); end
        gnt_l = 1'b1;
        tick();
        total++; if (cli_gnt !== 4'b0000) begin bad++; $display("FAIL wd_drop: got %b want 0000", cli_gnt); end
        total++; if (req_l !== 1'b0) begin bad++; $display("FAIL wd_req_l: got %b want 0", req_l); end
        tick(); tick();
        total++; if (cli_gnt !== 4'b0000) begin bad++; $display("FAIL wd_hold: got %b want 0000", cli_gnt); end
        gnt_l = 1'b0;
        tick();
        total++; if (cli_gnt !== 4'b1000) begin bad++; $display("FAIL wd_regnt: got %b want 1000", cli_gnt); end
        frame_l = 1'b0; irdy_l = 1'b0; tick();
        frame_l = 1'b1; irdy_l = 1'b1; cli_req = 4'b0000; tick();
        gnt_l = 1'b1; tick(); tick();
    endtask

    task automatic test_reset_mid();
        cli_req = 4'b0010; gnt_l = 1'b0;
        wait_gnt();
        frame_l = 1'b0; irdy_l = 1'b0;
        tick();
        total++; if (req_l !== 1'b0) begin bad++; $display("FAIL rm_pre_req_l: got %b want 0", req_l); end
        #2 reset = 1'b1;
        #1;
        total++; if (req_l !== 1'b1) begin bad++; $display("FAIL rm_req_l: got %b want 1", req_l); end
        total++; if (cli_gnt !== 4'b0000) begin bad++; $display("FAIL rm_cli_gnt: got %b want 0000", cli_gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b want 0", busy); end
        frame_l = 1'b1; irdy_l = 1'b1; cli_req = 4'b1111; gnt_l = 1'b0;
        reset = 1'b0;
        wait_gnt();
        total++; if (cli_gnt !== 4'b0001) begin bad++; $display("FAIL rm_first: got %b want 0001", cli_gnt); end
        frame_l = 1'b0; irdy_l = 1'b0; tick();
        frame_l = 1'b1; irdy_l = 1'b1; cli_req = 4'b0000; tick();
        gnt_l = 1'b1; tick(); tick();
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_lat_timer();
        test_timeout();
        test_gnt_withdraw();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
